// File: rtl/seq_alu.sv
// seq_alu: EX-stage ALU with single-cycle logic/arith/compare ops and iterative MULU/DIVU.
// Optional build macro SEQ_ALU_DIV_EN enables the restoring divider for code 1110.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADD2 = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0100;
    localparam logic [3:0] OP_NE   = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1100;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1110;
`endif

    function automatic logic [WIDTH-1:0] flag_ext(input logic flag);
        flag_ext = {{(WIDTH-1){1'b0}}, flag};
    endfunction

    // Undefined codes (and 1110 when it is not handled as a divide) yield zero.
    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:          single_op = a & b;
            OP_OR:           single_op = a | b;
            OP_ADD, OP_ADD2: single_op = a + b;
            OP_SUB:          single_op = a - b;
            OP_EQ:           single_op = flag_ext(a == b);
            OP_NE:           single_op = flag_ext(a != b);
            OP_SLTU:         single_op = flag_ext(a < b);
            OP_SLT:          single_op = flag_ext($signed(a) < $signed(b));
            default:         single_op = {WIDTH{1'b0}};
        endcase
    endfunction

    logic [0:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] hi_r;
    logic             done_r;
    logic             is_multi_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
`ifdef SEQ_ALU_DIV_EN
    logic             div_op_r;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] div_quo_s;
`endif

    // Decode which codes launch an iterative operation.
    always_comb begin
`ifdef SEQ_ALU_DIV_EN
        is_multi_s = (ctrl_i == OP_MULU) || (ctrl_i == OP_DIVU);
`else
        is_multi_s = (ctrl_i == OP_MULU);
`endif
    end

    // One shift-add multiply step: acc_lo holds the multiplier, consumed LSB first.
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_r} + {1'b0, opb_r};
        if (acc_lo_r[0]) begin
            mul_hi_s = mul_sum_s[WIDTH:1];
            mul_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end else begin
            mul_hi_s = {1'b0, acc_hi_r[WIDTH-1:1]};
            mul_lo_s = {acc_hi_r[0], acc_lo_r[WIDTH-1:1]};
        end
    end

`ifdef SEQ_ALU_DIV_EN
    // One restoring-divide step; a zero divisor always "fits", giving all-ones quotient.
    always_comb begin
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (div_shift_s >= {1'b0, opb_r}) begin
            div_rem_s = div_diff_s[WIDTH-1:0];
            div_quo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_s = div_shift_s[WIDTH-1:0];
            div_quo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Select the iteration result for the running op.
    always_comb begin
        if (div_op_r) begin
            step_hi_s = div_rem_s;
            step_lo_s = div_quo_s;
        end else begin
            step_hi_s = mul_hi_s;
            step_lo_s = mul_lo_s;
        end
    end
`else
    // Only the multiplier iterates in this build.
    always_comb begin
        step_hi_s = mul_hi_s;
        step_lo_s = mul_lo_s;
    end
`endif

    // Control FSM, iteration datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_op_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i && is_multi_s) begin
                        state_r  <= ST_RUN;
                        cnt_r    <= CNT_INIT;
                        acc_hi_r <= {WIDTH{1'b0}};
                        acc_lo_r <= src1_i;
                        opb_r    <= src2_i;
                        done_r   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
                        div_op_r <= (ctrl_i == OP_DIVU);
`endif
                    end else if (start_i) begin
                        result_r <= single_op(ctrl_i, src1_i, src2_i);
                        hi_r     <= {WIDTH{1'b0}};
                        done_r   <= 1'b1;
                    end else begin
                        done_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r  <= ST_IDLE;
                        result_r <= step_lo_s;
                        hi_r     <= step_hi_s;
                        done_r   <= 1'b1;
                    end else begin
                        done_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_r;
    assign hi_o     = hi_r;
    assign done_o   = done_r;
    assign busy_o   = (state_r == ST_RUN);
    assign zero_o   = (result_r == {WIDTH{1'b0}});

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath ALU for the single-cycle/multi-cycle CPU. It keeps the existing 4-bit operation encoding for single-cycle logic, add, subtract and compare ops, and adds iterative unsigned multiply and divide behind a start/busy/done handshake. Results are registered and held until the next completed operation. It sits in the EX stage; the control unit stalls the PC while `busy_o` is high.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 4)
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `start_i`  in  1  launch operation; sampled only when `busy_o`=0
- `ctrl_i`  in  4  operation code, sampled with `start_i`
- `src1_i`  in  WIDTH  operand A, sampled with `start_i`
- `src2_i`  in  WIDTH  operand B, sampled with `start_i`
- `result_o`  out  WIDTH  registered result (low product / quotient)
- `hi_o`  out  WIDTH  registered high product / remainder; 0 for other ops
- `zero_o`  out  1  combinational: `result_o` == 0
- `busy_o`  out  1  multi-cycle op in progress
- `done_o`  out  1  one-cycle pulse: `result_o`/`hi_o` just updated

## Operation
- Codes:
  - 0000: AND
  - 0001: OR
  - 0010, 1000: ADD (wraps mod 2^WIDTH)
  - 0110: SUB (wraps)
  - 0100: EQ → 1/0
  - 1010: NE → 1/0
  - 0101: SLTU (unsigned <) → 1/0
  - 0111: SLT (signed two's-complement <) → 1/0
  - 1100: MULU
  - 1110: DIVU
  - all others: result 0.
- The compare result is zero-extended to WIDTH.
- FSM states:
  - IDLE: accepts `start_i`.
    - Single-cycle or undefined code: register the result, set `hi_o`=0, pulse `done_o`, stay in IDLE.
    - MULU/DIVU: latch the operands, load an iteration counter with WIDTH, go to RUN.
  - RUN: one iteration per clock.
    - MULU: shift-add, 2·WIDTH-bit unsigned product. `hi_o`:`result_o` = {high, low}.
    - DIVU: restoring division, one quotient bit per clock. `result_o` = quotient, `hi_o` = remainder.
    - After the last iteration: write the outputs, pulse `done_o`, return to IDLE.
- Divide by zero needs no special case. The restoring algorithm gives quotient = all ones and remainder = dividend.
- `start_i` while `busy_o`=1 is ignored and has no effect on the running op.
- `result_o`/`hi_o` change only on a `done_o` cycle or on reset. Intermediate partial values never appear on the outputs.

## Timing
- Reset, at the first rising edge with `rst_i`=1:
  - `result_o`=0, `hi_o`=0, `busy_o`=0, `done_o`=0, `zero_o`=1, FSM=IDLE, counter=0.
  - Reset mid-RUN aborts the op; no `done_o` is produced.
  - `rst_i` overrides `start_i` in the same cycle.
- Single-cycle op: start sampled at edge k → outputs valid and `done_o`=1 during cycle k+1. Latency 1.
- MULU/DIVU: start at edge k →
  - `busy_o`=1 from edge k through edge k+WIDTH−1.
  - At edge k+WIDTH: outputs are written, `busy_o`=0, and `done_o`=1 for that cycle. Latency WIDTH.
- Back-to-back: a new `start_i` is accepted in the same cycle `done_o` is high (`busy_o` is already 0). Throughput is 1 op/cycle for single-cycle ops.
- `done_o` is never high for two consecutive cycles from a single start.

## Configuration
- Macro `SEQ_ALU_DIV_EN`:
  - Defined: DIVU (1110) is implemented as specified above.
  - Undefined: no divider logic is built. 1110 behaves as an undefined code: single-cycle, `result_o`=0, `hi_o`=0, `busy_o` stays 0.
- MULU and all other ops are unaffected by the macro.

## Test plan
All cases use WIDTH=32.
- Reset, then idle: after `rst_i` → `result_o`=0, `hi_o`=0, `zero_o`=1, `busy_o`=0, `done_o`=0.
- Single-cycle ops:
  - SLT with -1, 1 → 1. SLTU with 0xFFFFFFFF, 1 → 0.
  - ADD 0xFFFFFFFF+1 → 0, `zero_o`=1.
  - NE 5,5 → 0.
  - Each shows `done_o` one cycle after start.
- MULU 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `result_o`=0x00000001, with `busy_o` high for exactly 32 cycles and `done_o` at edge k+32.
- DIVU (macro defined):
  - 100/7 → `result_o`=14, `hi_o`=2.
  - 0x1234/0 → `result_o`=0xFFFFFFFF, `hi_o`=0x1234.
  - Without the macro: same stimulus → 0/0 with 1-cycle `done_o`.
- Pulse `start_i` with SUB at cycle 5 of a running MULU → ignored; the MULU result is correct and only one `done_o` occurs.
- Assert `rst_i` at cycle 10 of a MULU → outputs return to reset values and no `done_o` follows. A new ADD 2+3 issued afterwards → 5 after 1 cycle.
